// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, widths and FSM state type for alu_seq
//
// Purpose: common definitions imported by the alu_seq interface, top and
//          multiplier datapath.
// Contents: OP_W op-code width, OP_AND..OP_MUL op codes, state_e FSM states.
package alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND = 3'd0;
  localparam logic [OP_W-1:0] OP_OR  = 3'd1;
  localparam logic [OP_W-1:0] OP_ADD = 3'd2;
  localparam logic [OP_W-1:0] OP_SUB = 3'd3;
  localparam logic [OP_W-1:0] OP_MUL = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/result bundle between datapath and alu_seq
//
// Purpose: groups the request (start, A, B, S) and the registered result
//          (C, Hi, Co, Z, V, busy, done, err) of alu_seq.
// Modports: master drives requests and observes results; slave is the ALU.
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int W = 4
);

  logic            start;
  logic [W-1:0]    A;
  logic [W-1:0]    B;
  logic [OP_W-1:0] S;
  logic [W-1:0]    C;
  logic [W-1:0]    Hi;
  logic            Co;
  logic            Z;
  logic            V;
  logic            busy;
  logic            done;
  logic            err;

  modport master (
    output start, A, B, S,
    input  C, Hi, Co, Z, V, busy, done, err
  );

  modport slave (
    input  start, A, B, S,
    output C, Hi, Co, Z, V, busy, done, err
  );

endinterface

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - LSB-first shift-add unsigned multiplier datapath
//
// Purpose: one partial-product step per i_step; i_load restarts a product.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_load       latch i_a (multiplicand) and i_b (multiplier), clear acc
//   i_step       perform one shift-add step
//   i_a, i_b     W-bit operands
//   o_product    2W-bit accumulator including the step in progress; on the
//                W-th step it equals i_a * i_b
module alu_mul_seq #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_load,
  input  logic           i_step,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_product
);

  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [2*W-1:0] w_acc_nxt;

  // Exposing the post-step value lets the caller capture the finished product
  // on the same edge as the last step, keeping latency at exactly W cycles.
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_product = w_acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= {{W{1'b0}}, i_a};
      r_mplier <= i_b;
    end else if (i_step) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered W-bit ALU with start/busy/done and multi-cycle MUL
//
// Purpose: AND/OR/ADD/SUB complete in one cycle; MUL takes W cycles through
//          alu_mul_seq. All results and flags are registered and held until
//          the next operation completes.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          alu_seq_if slave: start/A/B/S in, C/Hi/Co/Z/V/busy/done/err out
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);

  localparam int CNT_W = (W > 2) ? $clog2(W) : 1;

  state_e         r_state;
  state_e         w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic           w_accept;
  logic           w_load;
  logic           w_step;
  logic           w_last;

  logic [2*W-1:0] w_product;

  logic [W-1:0]   w_res_c;
  logic           w_res_co;
  logic           w_res_v;
  logic           w_res_err;
  logic [W:0]     w_sum;
  logic [W:0]     w_diff;

  logic [W-1:0]   r_c;
  logic [W-1:0]   r_hi;
  logic           r_co;
  logic           r_z;
  logic           r_v;
  logic           r_busy;
  logic           r_done;
  logic           r_err;

  alu_mul_seq #(.W(W)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_a      (bus.A),
    .i_b      (bus.B),
    .o_product(w_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        // Accepting from DONE is what makes back-to-back requests possible.
        if (bus.start) begin
          w_accept = 1'b1;
          if (bus.S == OP_MUL) begin
            w_load      = 1'b1;
            w_state_nxt = MUL_RUN;
          end else begin
            w_state_nxt = DONE;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      MUL_RUN: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(W - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (w_step) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_sum  = {1'b0, bus.A} + {1'b0, bus.B};
  assign w_diff = {1'b0, bus.A} - {1'b0, bus.B};

  // Single-cycle result; illegal codes fall to the all-zero default with err.
  always_comb begin
    w_res_c   = '0;
    w_res_co  = 1'b0;
    w_res_v   = 1'b0;
    w_res_err = 1'b0;
    case (bus.S)
      OP_AND: w_res_c = bus.A & bus.B;
      OP_OR:  w_res_c = bus.A | bus.B;
      OP_ADD: begin
        w_res_c  = w_sum[W-1:0];
        w_res_co = w_sum[W];
        w_res_v  = (bus.A[W-1] == bus.B[W-1]) && (w_sum[W-1] != bus.A[W-1]);
      end
      OP_SUB: begin
        w_res_c  = w_diff[W-1:0];
        // The extended subtraction borrows into bit W exactly when A < B.
        w_res_co = ~w_diff[W];
        w_res_v  = (bus.A[W-1] != bus.B[W-1]) && (w_diff[W-1] != bus.A[W-1]);
      end
      default: w_res_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c    <= '0;
      r_hi   <= '0;
      r_co   <= 1'b0;
      r_z    <= 1'b1;
      r_v    <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == MUL_RUN);
      r_done <= (w_state_nxt == DONE);
      if (w_accept && !w_load) begin
        r_c   <= w_res_c;
        r_hi  <= '0;
        r_co  <= w_res_co;
        r_z   <= (w_res_c == '0);
        r_v   <= w_res_v;
        r_err <= w_res_err;
      end else if (w_last) begin
        r_c   <= w_product[W-1:0];
        r_hi  <= w_product[2*W-1:W];
        r_co  <= (w_product[2*W-1:W] != '0);
        r_z   <= (w_product[W-1:0] == '0);
        r_v   <= 1'b0;
        r_err <= 1'b0;
      end
    end
  end

  assign bus.C    = r_c;
  assign bus.Hi   = r_hi;
  assign bus.Co   = r_co;
  assign bus.Z    = r_z;
  assign bus.V    = r_v;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.err  = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq at W = 4
module tb_alu_seq;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_seq_if #(.W(4)) bus ();

  alu_seq #(.W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".C"},    32'(bus.C),    32'h0);
    check_val({tag, ".Hi"},   32'(bus.Hi),   32'h0);
    check_val({tag, ".Co"},   32'(bus.Co),   32'h0);
    check_val({tag, ".Z"},    32'(bus.Z),    32'h1);
    check_val({tag, ".V"},    32'(bus.V),    32'h0);
    check_val({tag, ".busy"}, 32'(bus.busy), 32'h0);
    check_val({tag, ".done"}, 32'(bus.done), 32'h0);
    check_val({tag, ".err"},  32'(bus.err),  32'h0);
  endtask

  // One single-cycle request; operands are scrambled right after the
  // accepting edge to show they are not needed afterwards.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] s, input logic [3:0] ec, input logic eco,
                        input logic ev, input logic ez, input logic eerr);
    bus.A = a; bus.B = b; bus.S = s; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.A = ~a; bus.B = ~b;
    check_val({tag, ".C"},    32'(bus.C),    32'(ec));
    check_val({tag, ".Hi"},   32'(bus.Hi),   32'h0);
    check_val({tag, ".Co"},   32'(bus.Co),   32'(eco));
    check_val({tag, ".V"},    32'(bus.V),    32'(ev));
    check_val({tag, ".Z"},    32'(bus.Z),    32'(ez));
    check_val({tag, ".err"},  32'(bus.err),  32'(eerr));
    check_val({tag, ".done"}, 32'(bus.done), 32'h1);
    check_val({tag, ".busy"}, 32'(bus.busy), 32'h0);
  endtask

  // MUL request; hold_c is the C value left by the previous operation, which
  // must stay visible while busy. inject fires an ADD start mid-run.
  task automatic run_mul(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] ehi, input logic [3:0] ec, input logic [3:0] hold_c,
                         input logic inject);
    bus.A = a; bus.B = b; bus.S = OP_MUL; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.A = 4'h1; bus.B = 4'h1; bus.S = OP_ADD;
    check_val({tag, ".busy0"}, 32'(bus.busy), 32'h1);
    check_val({tag, ".done0"}, 32'(bus.done), 32'h0);
    for (int i = 1; i < 4; i++) begin
      if (inject && i == 2) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check_val($sformatf("%s.busy%0d", tag, i), 32'(bus.busy), 32'h1);
      check_val($sformatf("%s.done%0d", tag, i), 32'(bus.done), 32'h0);
      check_val($sformatf("%s.hold%0d", tag, i), 32'(bus.C),    32'(hold_c));
    end
    @(posedge clk); #1;
    check_val({tag, ".done"}, 32'(bus.done), 32'h1);
    check_val({tag, ".busy"}, 32'(bus.busy), 32'h0);
    check_val({tag, ".Hi"},   32'(bus.Hi),   32'(ehi));
    check_val({tag, ".C"},    32'(bus.C),    32'(ec));
    check_val({tag, ".Co"},   32'(bus.Co),   32'(ehi != 4'h0));
    check_val({tag, ".Z"},    32'(bus.Z),    32'(ec == 4'h0));
    check_val({tag, ".V"},    32'(bus.V),    32'h0);
    check_val({tag, ".err"},  32'(bus.err),  32'h0);
    @(posedge clk); #1;
    check_val({tag, ".done_end"}, 32'(bus.done), 32'h0);
    check_val({tag, ".C_held"},   32'(bus.C),    32'(ec));
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic       co;
  } add_vec_t;

  add_vec_t b2b[4];

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.A = 4'h0; bus.B = 4'h0; bus.S = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // B = 0111, A = 1010
    run_op("add7", 4'b1010, 4'b0111, OP_ADD, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("sub7", 4'b1010, 4'b0111, OP_SUB, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("and7", 4'b1010, 4'b0111, OP_AND, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("or7",  4'b1010, 4'b0111, OP_OR,  4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_val("idle.done", 32'(bus.done), 32'h0);
    check_val("idle.C",    32'(bus.C),    32'hf);

    // B = 0011, A = 1010
    run_op("add3", 4'b1010, 4'b0011, OP_ADD, 4'b1101, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sub3", 4'b1010, 4'b0011, OP_SUB, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("and3", 4'b1010, 4'b0011, OP_AND, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("or3",  4'b1010, 4'b0011, OP_OR,  4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // MUL with an ignored start mid-run, then 15 x 15
    run_mul("mul_a7", 4'b1010, 4'b0111, 4'b0100, 4'b0110, 4'b1011, 1'b1);
    run_mul("mul_ff", 4'b1111, 4'b1111, 4'b1110, 4'b0001, 4'b0110, 1'b0);

    // Illegal op clears Hi left by the MUL; SUB of equal operands gives zero
    run_op("illegal", 4'b0011, 4'b0101, 3'd6, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
    run_op("sub_eq",  4'b0101, 4'b0101, OP_SUB, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);

    // Back-to-back ADDs with start held high
    b2b[0] = '{a: 4'h1, b: 4'h2, c: 4'h3, co: 1'b0};
    b2b[1] = '{a: 4'h7, b: 4'h8, c: 4'hf, co: 1'b0};
    b2b[2] = '{a: 4'h9, b: 4'h9, c: 4'h2, co: 1'b1};
    b2b[3] = '{a: 4'hf, b: 4'h1, c: 4'h0, co: 1'b1};
    bus.S = OP_ADD; bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.A = b2b[i].a; bus.B = b2b[i].b;
      @(posedge clk); #1;
      check_val($sformatf("b2b%0d.C", i),    32'(bus.C),    32'(b2b[i].c));
      check_val($sformatf("b2b%0d.Co", i),   32'(bus.Co),   32'(b2b[i].co));
      check_val($sformatf("b2b%0d.done", i), 32'(bus.done), 32'h1);
    end
    bus.start = 1'b0;

    // Reset in MUL cycle 2, after a nonzero result is on the outputs
    run_op("pre_rst", 4'h1, 4'h1, OP_ADD, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.A = 4'b1010; bus.B = 4'b0111; bus.S = OP_MUL; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_val("rst_mul.busy", 32'(bus.busy), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mul");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_val($sformatf("post_rst%0d.done", i), 32'(bus.done), 32'h0);
      check_val($sformatf("post_rst%0d.busy", i), 32'(bus.busy), 32'h0);
    end
    run_op("post_add", 4'h3, 4'h4, OP_ADD, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
